// File: rtl/csa_seq_add_ctrl.sv
// csa_seq_add_ctrl: WIDTH-bit adder that reuses one 4-bit carry-select adder,
// one nibble per cycle LSB first, with the carry chained through a register.
module Carry_Sel_Adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [2:0] lo, hi0, hi1, hi;
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, Cin};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    assign hi  = lo[2] ? hi1 : hi0;
    assign Sum  = {hi[1:0], lo[1:0]};
    assign Cout = hi[2];
endmodule

module csa_seq_add_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf
);
    localparam int CW = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-5:0] acc;
    logic [3:0]       sa, sb, s_sum;
    logic             s_cin, s_co;

    // Adder inputs are held at zero outside RUN to avoid needless toggling.
    assign sa    = (state == RUN) ? ra[{cnt, 2'b00} +: 4] : 4'd0;
    assign sb    = (state == RUN) ? rb[{cnt, 2'b00} +: 4] : 4'd0;
    assign s_cin = (state == RUN) ? carry : 1'b0;

    Carry_Sel_Adder u_csa (.a(sa), .b(sb), .Cin(s_cin), .Sum(s_sum), .Cout(s_co));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    carry <= s_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Sum   <= {s_sum, acc};
                        Cout  <= s_co;
                        ovf   <= (ra[WIDTH-1] == rb[WIDTH-1]) & (s_sum[3] != ra[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc[{cnt, 2'b00} +: 4] <= s_sum;
                    end
                end
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// tb_csa_seq_add_ctrl: directed and random checks of the sequential adder against an arithmetic model.
module tb_csa_seq_add_ctrl;
    localparam int W = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         Cin = 1'b0;
    logic         busy, done, Cout, ovf;
    logic [W-1:0] Sum;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0, held_ovf = 1'b0;

    csa_seq_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned full;
        int sfull;
        full  = int'(x) + int'(y) + int'(c);
        sfull = int'($signed(x)) + int'($signed(y)) + int'(c);
        held_sum  = full[W-1:0];
        held_cout = full[W];
        held_ovf  = (sfull > 32767) || (sfull < -32768);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, {16'd0, Sum}, {16'd0, held_sum});
        check({tag, "_cout"}, {31'd0, Cout}, {31'd0, held_cout});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, held_ovf});
    endtask

    task automatic check_running(input string tag);
        check({tag, "_run_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_run_done"}, {31'd0, done}, 32'd0);
        check({tag, "_run_hold"}, {16'd0, Sum}, {16'd0, held_sum});
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; Cin = c; start = 1'b1;
        tick;
        start = 1'b0;
        a = ~x; b = ~y; Cin = ~c;
        for (int i = 1; i <= NS; i++) begin
            check_running(tag);
            if (i < NS) tick;
        end
        model(x, y, c);
        tick;
        check_result(tag);
        tick;
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (3) tick;
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, Sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        run_add("wrap", 16'hFFFF, 16'h0001, 1'b0);
        check("wrap_const", {15'd0, Cout, Sum}, 32'h10000);
        run_add("posovf", 16'h7FFF, 16'h0001, 1'b0);
        check("posovf_const", {14'd0, ovf, Cout, Sum}, 32'h20000 | 32'h8000);
        run_add("negovf", 16'h8000, 16'h8000, 1'b0);
        check("negovf_const", {14'd0, ovf, Cout, Sum}, 32'h30000);
        run_add("cin", 16'h1234, 16'h4321, 1'b1);
        check("cin_const", {14'd0, ovf, Cout, Sum}, 32'h05556);

        for (int n = 0; n < 1000; n++)
            run_add("rand", W'($urandom), W'($urandom), 1'($urandom));

        // Restart during RUN is ignored and operands are not re-latched.
        a = 16'h0F0F; b = 16'h00F1; Cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        a = 16'h5555; b = 16'h2222; Cin = 1'b1; start = 1'b1;
        check_running("ign2");
        tick;
        a = 16'h3333; b = 16'h1111;
        check_running("ign3");
        tick;
        start = 1'b0;
        check_running("ign4");
        model(16'h0F0F, 16'h00F1, 1'b0);
        tick;
        check_result("ign");
        check("ign_const", {16'd0, Sum}, 32'h1000);
        tick;
        check("ign_idle", {31'd0, busy | done}, 32'd0);

        // Start held high: a completion every NS+1 cycles, each from its accepting edge.
        begin
            logic [W-1:0] xs [3];
            logic [W-1:0] ys [3];
            logic         cs [3];
            for (int k = 0; k < 3; k++) begin
                xs[k] = W'($urandom); ys[k] = W'($urandom); cs[k] = 1'($urandom);
            end
            a = xs[0]; b = ys[0]; Cin = cs[0]; start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick;
                a = ~a; b = ~b;
                for (int i = 1; i <= NS; i++) begin
                    check_running("b2b");
                    if (i < NS) tick;
                end
                model(xs[k], ys[k], cs[k]);
                tick;
                check_result("b2b");
                if (k < 2) begin
                    a = xs[k+1]; b = ys[k+1]; Cin = cs[k+1];
                end else begin
                    start = 1'b0;
                end
            end
            tick;
            check("b2b_idle", {31'd0, busy | done}, 32'd0);
        end

        // Reset mid-add aborts without a done pulse.
        a = 16'hABCD; b = 16'h1357; Cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, Sum}, 32'd0);
        check("abort_flags", {30'd0, Cout, ovf}, 32'd0);
        for (int i = 0; i < NS + 2; i++) begin
            tick;
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        run_add("post_rst", 16'h4000, 16'h4000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
